// File: rtl/gardner_ted_pkg.sv
// Gardner TED shared package.
// Width helpers, saturation and parameter checks.
package gardner_ted_pkg;

  localparam int SatW = 64;

  function automatic int full_bits(
    input int il,
    input int nc
  );
    return 2 * il + 1 + $clog2(nc);
  endfunction

  function automatic int acc_bits(
    input int il,
    input int nc,
    input int avg
  );
    return full_bits(il, nc) + avg;
  endfunction

  function automatic bit params_ok(
    input int sps,
    input int il,
    input int nc,
    input int avg,
    input int ow
  );
    return (sps >= 2) && (sps % 2 == 0) &&
           (il >= 2) && (nc >= 1) &&
           (avg >= 0) && (avg <= 8) &&
           (ow >= 2) && (ow <= SatW) &&
           (acc_bits(il, nc, avg) <= SatW);
  endfunction

  // Clamp to an ow-bit signed range when ow
  // cannot hold fb bits; otherwise pass through.
  function automatic logic signed [SatW-1:0] saturate(
    input logic signed [SatW-1:0] v,
    input int                     ow,
    input int                     fb
  );
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    if (ow >= fb || ow >= SatW) return v;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Per-channel sample delay line.
// Shifts on accepted samples; taps at Depth/2 and Depth.
module sample_delay_line #(
  parameter int Depth = 4,
  parameter int Width = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [Width-1:0] din,
  output logic signed [Width-1:0] tap_half,
  output logic signed [Width-1:0] tap_full
);

  logic signed [Width-1:0] sr [Depth];

  // Shift register: sr[k] holds x[n-1-k].
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < Depth; k++) sr[k] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int k = 1; k < Depth; k++) sr[k] <= sr[k-1];
    end
  end

  assign tap_half = sr[Depth/2-1];
  assign tap_full = sr[Depth-1];

endmodule

// File: rtl/gardner_ted_avg.sv
// N-channel Gardner timing-error detector.
// Averages 2^AvgLog2 strobes, saturates, flags overruns.
module gardner_ted_avg
  import gardner_ted_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12,
  parameter int NumChannels      = 2,
  parameter int AvgLog2          = 0,
  parameter int OutputLengthBits = 26
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumChannels*InputLengthBits-1:0] in,
  input  logic                                   in_valid,
  input  logic                                   trigger,
  input  logic                                   clear,
  output logic signed [OutputLengthBits-1:0]     out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   overrun
);

  localparam int IW = InputLengthBits;
  localparam int NC = NumChannels;
  localparam int FB = full_bits(IW, NC);
  localparam int AW = acc_bits(IW, NC, AvgLog2);
  localparam int CW = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int PW = 2 * IW + 1;

  if (!params_ok(SamplesPerSymbol, IW, NC,
                 AvgLog2, OutputLengthBits)) begin : g_bad
    $error("gardner_ted_avg: illegal parameters");
  end

  logic signed [IW-1:0] x      [NC];
  logic signed [IW-1:0] tap_h  [NC];
  logic signed [IW-1:0] tap_f  [NC];
  logic signed [IW:0]   diff   [NC];
  logic signed [PW-1:0] prod   [NC];

  for (genvar c = 0; c < NC; c++) begin : g_ch
    assign x[c] = in[c*IW +: IW];

    sample_delay_line #(
      .Depth(SamplesPerSymbol),
      .Width(IW)
    ) u_dl (
      .clk     (clk),
      .rst     (rst),
      .en      (in_valid),
      .clr     (clear),
      .din     (x[c]),
      .tap_half(tap_h[c]),
      .tap_full(tap_f[c])
    );

    assign diff[c] = (IW+1)'(tap_f[c])
                   - (IW+1)'(x[c]);
    assign prod[c] = PW'(diff[c]) * PW'(tap_h[c]);
  end

  logic signed [FB-1:0] e;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] avg;
  logic [CW-1:0]        cnt;
  logic                 strobe;
  logic                 last;
  logic                 done;
  logic signed [OutputLengthBits-1:0] res;

  // Full-precision sum of per-channel errors.
  always_comb begin
    e = '0;
    for (int c = 0; c < NC; c++) begin
      e = e + FB'(prod[c]);
    end
  end

  assign strobe  = in_valid && trigger && !clear;
  assign last    = (AvgLog2 == 0) ? 1'b1
                 : (cnt == CW'((1 << AvgLog2) - 1));
  assign done    = strobe && last;
  assign acc_sum = acc + AW'(e);
  assign avg     = acc_sum >>> AvgLog2;
  assign res     = OutputLengthBits'(
                     saturate(SatW'(avg),
                              OutputLengthBits, FB));

  // Accumulate strobes; restart after each result.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (strobe) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output register with valid/ready and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      out       <= res;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gardner_ted_avg.sv
// Directed bench for gardner_ted_avg.
// Three instances: base, saturating, averaging.
module tb_gardner_ted_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] in_s = '0;
  logic        in_valid = 1'b0;
  logic        trigger = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic signed [25:0] out_b;
  logic               vld_b;
  logic               ovr_b;
  logic signed [19:0] out_s;
  logic               vld_s;
  logic               ovr_s;
  logic signed [25:0] out_a;
  logic               vld_a;
  logic               ovr_a;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gardner_ted_avg #(
    .SamplesPerSymbol(4), .InputLengthBits(12),
    .NumChannels(2), .AvgLog2(0),
    .OutputLengthBits(26)
  ) dut (
    .clk(clk), .rst(rst), .in(in_s),
    .in_valid(in_valid), .trigger(trigger),
    .clear(clear), .out(out_b), .out_valid(vld_b),
    .out_ready(out_ready), .overrun(ovr_b)
  );

  gardner_ted_avg #(
    .SamplesPerSymbol(4), .InputLengthBits(12),
    .NumChannels(2), .AvgLog2(0),
    .OutputLengthBits(20)
  ) dut_s (
    .clk(clk), .rst(rst), .in(in_s),
    .in_valid(in_valid), .trigger(trigger),
    .clear(clear), .out(out_s), .out_valid(vld_s),
    .out_ready(out_ready), .overrun(ovr_s)
  );

  gardner_ted_avg #(
    .SamplesPerSymbol(4), .InputLengthBits(12),
    .NumChannels(2), .AvgLog2(2),
    .OutputLengthBits(26)
  ) dut_a (
    .clk(clk), .rst(rst), .in(in_s),
    .in_valid(in_valid), .trigger(trigger),
    .clear(clear), .out(out_a), .out_valid(vld_a),
    .out_ready(out_ready), .overrun(ovr_a)
  );

  task automatic chk(
    input string              tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, want %0d",
                tag, obs, exp);
  endtask

  task automatic step(
    input int i, input int q,
    input bit v, input bit t,
    input bit r, input bit c
  );
    logic [11:0] iv;
    logic [11:0] qv;
    iv = i[11:0];
    qv = q[11:0];
    in_s      = {qv, iv};
    in_valid  = v;
    trigger   = t;
    out_ready = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(0, 0, 1, 1, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // Reset state
    rst = 1'b1;
    step(5, 5, 1, 1, 1, 1);
    step(5, 5, 1, 1, 1, 0);
    rst = 1'b0;
    chk("rst_out", $signed(out_b), 0);
    chk("rst_valid", vld_b, 0);
    chk("rst_ovr", ovr_b, 0);
    chk("rst_valid_a", vld_a, 0);

    // Independence and latency
    for (int k = 0; k < 14; k++) begin
      step(k, 200 + k, 1, 1, 1, 0);
      if (k >= 10) begin
        chk($sformatf("ramp_out_%0d", k), $signed(out_b),
            -4 * (k - 2) - 4 * (200 + k - 2));
        chk($sformatf("ramp_vld_%0d", k), vld_b, 1);
      end
    end

    // Worst case and saturation
    do_rst();
    for (int k = 0; k < 6; k++) begin
      step(-2048, -2048, 1, 1, 1, 0);
      if (k >= 4) begin
        chk("worst_flat", $signed(out_b), 0);
        chk("worst_flat_s", $signed(out_s), 0);
      end
    end
    step(2047, 2047, 1, 1, 1, 0);
    chk("worst_full", $signed(out_b), 16773120);
    chk("worst_sat", $signed(out_s), 524287);

    // Handshake and overrun
    do_rst();
    for (int k = 0; k < 4; k++) step(k, k, 1, 0, 0, 0);
    step(4, 4, 1, 1, 0, 0);
    chk("hs_first", $signed(out_b), -16);
    chk("hs_first_v", vld_b, 1);
    step(5, 5, 1, 1, 1, 0);
    chk("hs_acc_new", $signed(out_b), -24);
    chk("hs_acc_new_v", vld_b, 1);
    chk("hs_acc_no_ovr", ovr_b, 0);
    step(6, 6, 1, 1, 0, 0);
    chk("hs_ovr_out", $signed(out_b), -32);
    chk("hs_ovr", ovr_b, 1);
    step(7, 7, 1, 0, 1, 0);
    chk("hs_drain_v", vld_b, 0);
    chk("hs_drain_out", $signed(out_b), -32);
    chk("hs_sticky", ovr_b, 1);

    // Trigger ignored without in_valid
    for (int k = 0; k < 100; k++) step(99, -99, 0, 1, 0, 0);
    chk("gate_out", $signed(out_b), -32);
    chk("gate_v", vld_b, 0);
    step(8, 8, 1, 1, 0, 0);
    chk("gate_resume", $signed(out_b), -48);
    chk("gate_resume_v", vld_b, 1);

    // Averaging over four strobes
    do_rst();
    for (int k = 0; k < 14; k++) begin
      step(k, k, 1, k >= 10, 0, 0);
      if (k >= 10 && k <= 12) begin
        chk($sformatf("avg_v_%0d", k), vld_a, 0);
        chk($sformatf("avg_o_%0d", k), $signed(out_a), 0);
      end
    end
    chk("avg_out", $signed(out_a), -76);
    chk("avg_v", vld_a, 1);

    // Reset mid-average
    step(14, 14, 1, 1, 0, 0);
    step(15, 15, 1, 1, 0, 0);
    do_rst();
    chk("mid_rst_out", $signed(out_a), 0);
    chk("mid_rst_v", vld_a, 0);
    chk("mid_rst_ovr", ovr_a, 0);

    // Clear mid-average
    for (int k = 0; k < 12; k++) step(k, k, 1, k >= 10, 0, 0);
    chk("pre_clr_v", vld_a, 0);
    step(12, 12, 1, 1, 0, 1);
    chk("clr_v", vld_a, 0);
    for (int k = 13; k < 21; k++) begin
      step(k, k, 1, k >= 17, 0, 0);
      if (k == 19) chk("clr_partial_v", vld_a, 0);
    end
    chk("clr_avg_out", $signed(out_a), -132);
    chk("clr_avg_v", vld_a, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gardner_ted_avg.md
Name: gardner_ted_avg

Overview:
Parametrised N-channel Gardner timing-error detector with symbol-error averaging, output saturation and overrun reporting. It sits between the matched filter and the symbol-timing loop filter. NumChannels=1 serves real BPSK/PAM; NumChannels=2 serves I/Q QAM. Averaging over 2^AvgLog2 triggered symbols lowers the loop-filter update rate and error variance.

Parameters:
SamplesPerSymbol, 4, samples per symbol; even, >=2.
InputLengthBits, 12, signed sample width per channel.
NumChannels, 2, number of sample-aligned channels; >=1.
AvgLog2, 0, log2 of the number of triggered errors averaged per output; 0..8.
OutputLengthBits, 26, signed output width; full precision is FullBits = 2*InputLengthBits+1+$clog2(NumChannels).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in  in  NumChannels*InputLengthBits  packed signed samples; channel c occupies bits [c*InputLengthBits +: InputLengthBits].
in_valid  in  1  shared valid for all channels; one sample per channel is accepted per asserted cycle.
trigger  in  1  asserted with in_valid on the mid-symbol strobe sample; ignored when in_valid=0.
clear  in  1  synchronous flush of delay lines, accumulator and counter; output register untouched.
out  out  OutputLengthBits  signed averaged timing error.
out_valid  out  1  output holds an unconsumed result.
out_ready  in  1  downstream accepts out when out_valid=1.
overrun  out  1  sticky: a result was overwritten before it was consumed.

Behaviour:
- Reset (rst=1 at edge): delay taps, accumulator, counter, out, out_valid and overrun all go to 0. rst dominates every other input.
- Delay line per channel: on in_valid=1, shift in x[n]. Keep taps x[n-SamplesPerSymbol/2] and x[n-SamplesPerSymbol], counted in accepted samples, not cycles.
- Error on strobe (in_valid=1 and trigger=1): e = sum over c of (x_c[n-SPS] - x_c[n]) * x_c[n-SPS/2].
  - x_c[n] is the sample presented in that same cycle.
  - The difference is InputLengthBits+1 bits, the product 2*InputLengthBits+1 bits, and the sum FullBits. No overflow is possible at full precision.
- Accumulator: FullBits+AvgLog2 bits; counter: AvgLog2 bits.
  - On each strobe: acc += e and cnt += 1.
  - On the 2^AvgLog2-th strobe: result = (acc + e) >>> AvgLog2 (arithmetic shift, floor). acc and cnt both go to 0.
  - AvgLog2=0: every strobe produces a result.
- Saturation: if OutputLengthBits < FullBits, clamp result to [-2^(OutputLengthBits-1), 2^(OutputLengthBits-1)-1]; otherwise sign-extend.
- Latency: out and out_valid update on the same edge as the completing strobe, i.e. visible 1 cycle after the stimulus cycle.
- Handshake:
  - A result edge sets out_valid=1 and loads out.
  - out_valid=1 and out_ready=1 with no new result: out_valid goes to 0 and out holds its value.
  - A new result in the same cycle as an accept: the new result wins, out_valid stays 1, no overrun.
  - out_valid=1, out_ready=0 and a new result: out is overwritten and overrun is set to 1, sticky until rst.
- No-trigger cycles with in_valid=1: only the delay lines shift; out and out_valid are unchanged.
- in_valid=0: nothing changes, and trigger is ignored.
- clear=1: taps, acc and cnt go to 0 on that edge. Any strobe in the same cycle is discarded. out, out_valid and overrun are unaffected.

Decomposition:
- Package gardner_ted_pkg holds:
  - width helper functions: full_bits(InputLengthBits, NumChannels) and acc_bits(...).
  - a saturate function.
  - a parameter-legality check used in an initial assertion (SamplesPerSymbol even, AvgLog2 <= 8).
- Sub-module sample_delay_line: one instance per channel, holding a SamplesPerSymbol-deep shift register with an enable, a synchronous clear, and taps at SamplesPerSymbol/2 and SamplesPerSymbol.

Test Plan:
- Parameters SPS=4, NC=2, AvgLog2=0, OutputLengthBits=26 for all cases unless stated.
- Independence and latency: I ramps from 0 and Q ramps from 200, trigger=1 every cycle, warm-up of 10 samples -> each cycle out = -4*(I-2) + -4*(Q-2), using the previous-cycle inputs.
- Worst case: all inputs -2048 for 4 samples, then 2047 -> out=0 while inputs are constant, then out=16773120. Repeat with OutputLengthBits=20 -> out=524287 (saturated).
- Averaging (AvgLog2=2): I=Q ramp 0,1,2,..., trigger only on samples 10..13 -> per-strobe errors are -64, -72, -80, -88. out_valid rises once, after sample 13, with out=-76; out is unchanged after samples 10..12.
- Handshake and overrun: out_ready=0, two results -> out_valid=1, out = second result, overrun=1. Then out_ready=1 for one cycle -> out_valid=0, overrun stays 1. A result on the same cycle as an accept -> out_valid stays 1, no new overrun.
- Trigger/valid gating: trigger=1 with in_valid=0 for 100 cycles -> out and out_valid unchanged, taps frozen. Resume in_valid -> errors use accepted-sample indexing.
- Reset/clear mid-average (AvgLog2=2): 2 strobes then rst -> all outputs 0. 2 strobes then clear, then 4 strobes -> out equals the average of the last 4 only.
